// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: load/store funct3 encodings and the MEM-stage FSM states.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} mem_fsm_t;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (funct3)
         F3_H, F3_HU: mis = off[0];
         F3_W:        mis = (off != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/grant/response data-memory bus between the MEM stage and the data memory.
interface mem_access_unit_if #(parameter int unsigned ADDR_W = 32);

   logic              dmem_req_o;
   logic              dmem_we_o;
   logic [3:0]        dmem_be_o;
   logic [ADDR_W-1:0] dmem_addr_o;
   logic [31:0]       dmem_wdata_o;
   logic              dmem_gnt_i;
   logic              dmem_rvalid_i;
   logic [31:0]       dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
      input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
      output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
   );

endinterface

// File: rtl/load_store_align.sv
// Byte-enable generation, store lane replication and load extraction/extension.
module load_store_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_fmt
);

   logic [1:0]  off;
   logic [31:0] shifted;

   always_comb begin
      off        = '0;
      be         = '1;
      wdata_lane = wdata;
      rdata_fmt  = '0;
      // Offset is forced to natural alignment so halfword/word lanes never straddle.
      case (funct3)
         F3_B, F3_BU: begin
            off        = addr_lo;
            be         = 4'b0001 << off;
            wdata_lane = {4{wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            off        = {addr_lo[1], 1'b0};
            be         = 4'b0011 << off;
            wdata_lane = {2{wdata[15:0]}};
         end
         default: ;
      endcase
      shifted = rdata >> {off, 3'b000};
      case (funct3)
         F3_B:    rdata_fmt = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   rdata_fmt = {24'b0, shifted[7:0]};
         F3_H:    rdata_fmt = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   rdata_fmt = {16'b0, shifted[15:0]};
         default: rdata_fmt = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one outstanding bus transaction, stalls the pipeline until it completes.
// Optional misaligned-access trap: define MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              mem_valid_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [2:0]        mem_funct3_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   mem_access_unit_if.master bus,
   output logic [31:0]       mem_rdata_o,
   output logic              stall_o,
   output logic              misalign_o
);

   mem_fsm_t    state, state_nxt;
   logic        access, misal, req;
   logic [3:0]  be;
   logic [31:0] wdata_lane, rdata_fmt;

   // rst gates access so every output is quiet while reset is held.
   assign access = mem_valid_i & (mem_read_i | mem_write_i) & ~rst;

   load_store_align u_align (
      .funct3     (mem_funct3_i),
      .addr_lo    (mem_addr_i[1:0]),
      .wdata      (mem_wdata_i),
      .rdata      (bus.dmem_rdata_i),
      .be         (be),
      .wdata_lane (wdata_lane),
      .rdata_fmt  (rdata_fmt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      stall_o   = 1'b0;
      case (state)
         IDLE: if (access && !flush_i && !misal) begin
            req       = 1'b1;
            stall_o   = 1'b1;
            state_nxt = bus.dmem_gnt_i ? WAIT : REQ;
         end
         REQ: begin
            req     = 1'b1;
            stall_o = 1'b1;
            if (bus.dmem_gnt_i) state_nxt = flush_i ? DRAIN : WAIT;
            else if (flush_i)   state_nxt = IDLE;
         end
         WAIT: begin
            stall_o = 1'b1;
            if (bus.dmem_rvalid_i) state_nxt = flush_i ? IDLE : DONE;
            else if (flush_i)      state_nxt = DRAIN;
         end
         DRAIN: begin
            stall_o = 1'b1;
            if (bus.dmem_rvalid_i) state_nxt = IDLE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.dmem_req_o   = req;
   assign bus.dmem_we_o    = req & mem_write_i;
   assign bus.dmem_be_o    = req ? be : '0;
   assign bus.dmem_addr_o  = req ? {mem_addr_i[ADDR_W-1:2], 2'b00} : '0;
   assign bus.dmem_wdata_o = (req && mem_write_i) ? wdata_lane : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mem_rdata_o <= '0;
      else if (state == WAIT && bus.dmem_rvalid_i && !flush_i && mem_read_i)
         mem_rdata_o <= rdata_fmt;
   end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   logic misalign_q;

   assign misal = is_misaligned(mem_funct3_i, mem_addr_i[1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= (state == IDLE) && access && !flush_i && misal;
   end

   assign misalign_o = misalign_q;
`else
   assign misal      = 1'b0;
   assign misalign_o = 1'b0;
`endif

endmodule
